parallax_scroller: RTL
======================

Name: parallax_scroller

Overview:
- Multi-layer background scroll generator for the game engine's background renderer; one instance drives every parallax layer.
- Keeps a fixed-point horizontal position per layer that decreases at a score-dependent speed. Layer 0 is the fastest; each deeper layer is progressively slower.
- Outputs each layer's pixel X and seam skip value, plus per-layer wrap pulses.
- Adds over the single-layer scroller: layer count, speed clamp, pause, remainder-preserving wrap, wrap events and wrap counter.

Parameters:
- LAYERS, 2: number of parallax layers.
- SCREEN_W, 640: screen width in pixels; wrap period.
- FRAC_SCALE, 100: position sub-pixel scale; position = pixels * FRAC_SCALE.
- POS_W, 20: position register width; must hold SCREEN_W*FRAC_SCALE.
- SCORE_W, 10: score width.
- XW, 10: pixel output width per layer.
- MIN_SPEED, 100: base step at score 0, in sub-pixel units per tick.
- SPEED_PER_SCORE, 30: step added per score point.
- MAX_STEP, 4000: step clamp; must be less than SCREEN_W*FRAC_SCALE.
- LAYER_SHIFT, 1: layer k step = base step >> (k*LAYER_SHIFT), with a floor of 1.
- SEAM, 5: seam overlap in pixels used for the skip output.

Ports:
- animationClOCK  in  1  animation tick clock, one update per rising edge.
- reset  in  1  synchronous, active-high reset.
- score  in  SCORE_W  current game score.
- pause  in  1  high = positions frozen.
- layer_x  out  LAYERS*XW  packed pixel X; layer k occupies bits [k*XW +: XW].
- layer_skipx  out  LAYERS*XW  packed seam skip X, same packing as layer_x.
- layer_wrap  out  LAYERS  one-cycle pulse per layer on that layer's wrap.
- wrap_count  out  8  count of layer-0 wraps, modulo 256.

Behaviour:
- FULL = SCREEN_W*FRAC_SCALE = 64000 at defaults.
- All arithmetic is unsigned and computed at POS_W bits.
- Stage 1, speed register step_q, updated every clock including while paused:
  - base = MIN_SPEED + SPEED_PER_SCORE*score.
  - step_q = min(base, MAX_STEP).
  - A score change takes effect on position updates one clock later.
- Stage 2, per-layer step: s_k = step_q >> (k*LAYER_SHIFT); if s_k = 0 then s_k = 1. Purely combinational from step_q.
- Stage 3, per-layer position pos_k, registered:
  - pause = 1: pos_k holds; layer_wrap = 0.
  - pos_k >= s_k: pos_k <= pos_k - s_k; layer_wrap[k] = 0.
  - pos_k < s_k: pos_k <= pos_k + FULL - s_k; layer_wrap[k] = 1 for exactly that clock. The sub-pixel remainder is preserved.
  - pos_k = s_k exactly gives 0, which is not a wrap. The wrap happens on the following tick.
- Outputs, combinational from pos_k:
  - layer_x[k] = pos_k / FRAC_SCALE, truncated. Range 0..SCREEN_W.
  - d = SCREEN_W - layer_x[k].
  - layer_skipx[k] = 0 if d <= SEAM, else d - SEAM.
- wrap_count increments on each layer_wrap[0] pulse and rolls 255 -> 0.
- Reset, synchronous and taking priority over pause and score:
  - pos_k = FULL, so layer_x = SCREEN_W (640) and layer_skipx = 0.
  - step_q = MIN_SPEED clamped to MAX_STEP.
  - layer_wrap = 0; wrap_count = 0.
  - Reset asserted mid-scroll discards the position; the first update after deassert starts from FULL.
- Simultaneous wraps on several layers in one clock: every corresponding layer_wrap bit is set.
- Pause released on a clock where a wrap would occur: the wrap proceeds normally on that edge.

Test Plan:
- Reset, then score=0, pause=0, 1 tick → layer_x0=639 (pos 63900), layer_x1=639 (pos 63950, s_1=50), layer_skipx0=0 (d=1). After 10 ticks → layer_x0=630, skipx0=5.
- score=0, run 641 ticks from reset → pos_0 reaches 0 at tick 640 with layer_wrap[0]=0. Tick 641 → pos_0=63900, layer_wrap[0]=1 for one clock, wrap_count=1. Layer 1 does not wrap (pos_1=31950).
- Clamp and latency: score=200, which would give base 6100 → step_q=4000 one clock after score is applied. Next tick pos_0 decreases by 4000; s_1=2000.
- Pause: pause=1 for 20 ticks with score changing 0→5 → positions and outputs unchanged, no wrap pulses. After release, pos_0 decreases by 250 per tick.
- Remainder wrap: score=10 (s_0=400), pos_0 preset via ticks to 150 → next tick pos_0=63750, layer_x0=637, layer_wrap[0]=1.
- Reset mid-operation: assert reset for 1 clock at an arbitrary point → next cycle layer_x=640 on all layers, wrap_count=0. LAYERS=4, LAYER_SHIFT=4 build → layer 3 step is floored to 1 (100>>12=0→1).

Source files
------------

// File: rtl/parallax_scroller.sv
// Multi-layer parallax scroll generator: one fixed-point position per layer,
// each deeper layer stepping at a right-shifted fraction of the score speed.
module parallax_scroller #(
    parameter int LAYERS          = 2,
    parameter int SCREEN_W        = 640,
    parameter int FRAC_SCALE      = 100,
    parameter int POS_W           = 20,
    parameter int SCORE_W         = 10,
    parameter int XW              = 10,
    parameter int MIN_SPEED       = 100,
    parameter int SPEED_PER_SCORE = 30,
    parameter int MAX_STEP        = 4000,
    parameter int LAYER_SHIFT     = 1,
    parameter int SEAM            = 5
) (
    input  logic                 animationClOCK,
    input  logic                 reset,
    input  logic [SCORE_W-1:0]   score,
    input  logic                 pause,
    output logic [LAYERS*XW-1:0] layer_x,
    output logic [LAYERS*XW-1:0] layer_skipx,
    output logic [LAYERS-1:0]    layer_wrap,
    output logic [7:0]           wrap_count
);

    localparam logic [POS_W-1:0] FULL   = POS_W'(SCREEN_W * FRAC_SCALE);
    localparam logic [POS_W-1:0] MIN_P  = POS_W'(MIN_SPEED);
    localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX_STEP);
    localparam logic [POS_W-1:0] SPS_P  = POS_W'(SPEED_PER_SCORE);
    localparam logic [POS_W-1:0] FRAC_P = POS_W'(FRAC_SCALE);
    localparam logic [POS_W-1:0] SCR_P  = POS_W'(SCREEN_W);
    localparam logic [POS_W-1:0] SEAM_P = POS_W'(SEAM);
    localparam logic [POS_W-1:0] STEP0  = (MIN_P > MAX_P) ? MAX_P : MIN_P;

    logic [POS_W-1:0] base;
    logic [POS_W-1:0] step_d;
    logic [POS_W-1:0] step_q;
    logic [POS_W-1:0] pos_q [LAYERS];
    logic [POS_W-1:0] s     [LAYERS];

    assign base   = MIN_P + SPS_P * POS_W'(score);
    assign step_d = (base > MAX_P) ? MAX_P : base;

    // Deeper layers get a shifted step, floored at 1 so they never stall
    always_comb begin
        for (int k = 0; k < LAYERS; k++) begin
            s[k] = step_q >> (k * LAYER_SHIFT);
            if (s[k] == '0)
                s[k] = POS_W'(1);
        end
    end

    always_ff @(posedge animationClOCK) begin
        if (reset) begin
            step_q     <= STEP0;
            layer_wrap <= '0;
            wrap_count <= '0;
            for (int k = 0; k < LAYERS; k++)
                pos_q[k] <= FULL;
        end else begin
            step_q     <= step_d;
            layer_wrap <= '0;
            if (!pause) begin
                for (int k = 0; k < LAYERS; k++) begin
                    if (pos_q[k] >= s[k]) begin
                        pos_q[k] <= pos_q[k] - s[k];
                    end else begin
                        pos_q[k]      <= pos_q[k] + FULL - s[k];
                        layer_wrap[k] <= 1'b1;
                    end
                end
                if (pos_q[0] < s[0])
                    wrap_count <= wrap_count + 8'd1;
            end
        end
    end

    for (genvar k = 0; k < LAYERS; k++) begin : g_out
        logic [POS_W-1:0] xw;
        logic [POS_W-1:0] d;
        logic [POS_W-1:0] skip;

        assign xw   = pos_q[k] / FRAC_P;
        assign d    = SCR_P - xw;
        assign skip = (d <= SEAM_P) ? '0 : d - SEAM_P;

        assign layer_x[k*XW +: XW]     = XW'(xw);
        assign layer_skipx[k*XW +: XW] = XW'(skip);
    end

endmodule
